// File: rtl/mmio_port_responder_pkg.sv
// Shared constants for the MMIO port responder: register offsets, STATUS bit positions
// and the debounce FSM state encoding.
package mmio_port_pkg;

    localparam logic [1:0] OFF_OUT    = 2'd0;
    localparam logic [1:0] OFF_IN     = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_XOR    = 2'd3;

    localparam int ST_CHANGED = 0;
    localparam int ST_IE      = 1;
    localparam int ST_BUSY    = 2;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } debounceState_t;

endpackage

// File: rtl/mmio_port_responder_debouncer.sv
// Input path for the MMIO port: two-flop synchronizer followed by a debounce FSM that only
// commits a new PortIn value after it has stayed stable for DEBOUNCE_CYCLES clocks.
module port_in_debouncer
    import mmio_port_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int IN_WIDTH        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] portIn,
    output logic [IN_WIDTH-1:0] inReg,
    output logic                commit,
    output logic                busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [IN_WIDTH-1:0] sync1;
    logic [IN_WIDTH-1:0] sync2;
    logic [IN_WIDTH-1:0] cand;
    logic [CNT_W-1:0]    cnt;
    debounceState_t      state;

    // The commit is combinational so the top can raise CHANGED on the same edge IN_REG updates.
    always_comb begin
        busy   = (state == ST_COUNTING);
        commit = (state == ST_COUNTING) && (sync2 == cand) && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            cnt   <= '0;
            inReg <= '0;
            state <= ST_STABLE;
        end else begin
            sync1 <= portIn;
            sync2 <= sync1;
            case (state)
                ST_STABLE: begin
                    if (sync2 != inReg) begin
                        state <= ST_COUNTING;
                        cand  <= sync2;
                        cnt   <= '0;
                    end
                end
                ST_COUNTING: begin
                    if (sync2 != cand) begin
                        cand <= sync2;
                        cnt  <= '0;
                        if (sync2 == inReg) begin
                            state <= ST_STABLE;
                        end
                    end else if (cnt == CNT_LAST) begin
                        inReg <= cand;
                        state <= ST_STABLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_STABLE;
            endcase
        end
    end

endmodule

// File: rtl/mmio_port_responder.sv
// Memory-mapped port responder: decodes a 16-byte window holding OUT_REG, IN_REG, STATUS and
// OUT_XOR. Define MMIO_PORT_IRQ_EN to enable the STATUS.IE bit and the IrqOut change interrupt.
module mmio_port_responder
    import mmio_port_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h1001_0100,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter int          IN_WIDTH        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    output logic [31:0]         ReadData,
    output logic                Hit,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         PortOut,
    output logic                IrqOut
);

    logic [1:0]          offset;
    logic                writeEn;
    logic [31:0]         outReg;
    logic                changed;
    logic                ie;
    logic [IN_WIDTH-1:0] inReg;
    logic                commit;
    logic                busy;
    logic [31:0]         inRegExt;
    logic [31:0]         statusWord;
    logic                unusedAddrBits;

    port_in_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .IN_WIDTH(IN_WIDTH)
    ) debouncer (
        .clk(clk),
        .reset(reset),
        .portIn(PortIn),
        .inReg(inReg),
        .commit(commit),
        .busy(busy)
    );

    assign unusedAddrBits = ^Address[1:0];
    assign offset  = Address[3:2];
    assign Hit     = (Address[31:4] == BASE_ADDR[31:4]);
    assign writeEn = MemWrite && Hit;
    assign PortOut = outReg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outReg <= '0;
        end else if (writeEn && offset == OFF_OUT) begin
            outReg <= WriteData;
        end else if (writeEn && offset == OFF_XOR) begin
            outReg <= outReg ^ WriteData;
        end
    end

    // A debounce commit on the same edge as a W1C keeps CHANGED set so no event is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            changed <= 1'b0;
        end else if (commit) begin
            changed <= 1'b1;
        end else if (writeEn && offset == OFF_STATUS && WriteData[ST_CHANGED]) begin
            changed <= 1'b0;
        end
    end

`ifdef MMIO_PORT_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie <= 1'b0;
        end else if (writeEn && offset == OFF_STATUS) begin
            ie <= WriteData[ST_IE];
        end
    end

    assign IrqOut = changed && ie;
`else
    assign ie     = 1'b0;
    assign IrqOut = 1'b0;
`endif

    always_comb begin
        inRegExt                 = '0;
        inRegExt[IN_WIDTH-1:0]   = inReg;
        statusWord               = '0;
        statusWord[ST_CHANGED]   = changed;
        statusWord[ST_IE]        = ie;
        statusWord[ST_BUSY]      = busy;
    end

    always_comb begin
        ReadData = '0;
        if (MemRead && Hit) begin
            case (offset)
                OFF_OUT:    ReadData = outReg;
                OFF_IN:     ReadData = inRegExt;
                OFF_STATUS: ReadData = statusWord;
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed testbench for mmio_port_responder; define MMIO_PORT_IRQ_EN to exercise the interrupt build.
module tb_mmio_port_responder;

    localparam logic [31:0] BASE   = 32'h1001_0100;
    localparam logic [31:0] A_OUT  = BASE + 32'h0;
    localparam logic [31:0] A_IN   = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_XOR  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic        IrqOut;

    int errors = 0;
    int checks = 0;

    mmio_port_responder #(
        .BASE_ADDR(BASE),
        .DEBOUNCE_CYCLES(4),
        .IN_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Address(Address),
        .WriteData(WriteData),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .ReadData(ReadData),
        .Hit(Hit),
        .PortIn(PortIn),
        .PortOut(PortOut),
        .IrqOut(IrqOut)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] addr, output logic [31:0] data, output logic hit);
        Address = addr;
        MemRead = 1'b1;
        #1;
        data    = ReadData;
        hit     = Hit;
        MemRead = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic        h;
        busWrite(A_OUT, 32'hDEAD_BEEF);
        PortIn = 8'h81;
        repeat (12) @(negedge clk);
        busRead(A_IN, d, h);
        checks++;
        if (d !== 32'h0000_0081) begin errors++; $display("[TB] FAIL reset_pre_in: got %h expected %h", d, 32'h81); end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (PortOut !== 32'h0) begin errors++; $display("[TB] FAIL reset_portout: got %h expected 0", PortOut); end
        checks++;
        if (IrqOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", IrqOut); end
        busRead(A_IN, d, h);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_in: got %h expected 0", d); end
        busRead(A_STAT, d, h);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_status: got %h expected 0", d); end
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        busRead(A_IN, d, h);
        checks++;
        if (d !== 32'h0000_0081) begin errors++; $display("[TB] FAIL reset_redebounce: got %h expected %h", d, 32'h81); end
        PortIn = 8'h00;
        repeat (10) @(negedge clk);
        busWrite(A_STAT, 32'h1);
        busRead(A_STAT, d, h);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_cleanup_status: got %h expected 0", d); end
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        logic        h;
        @(negedge clk);
        PortIn = 8'h3C;
        repeat (2) @(negedge clk);
        PortIn = 8'h00;
        repeat (10) @(negedge clk);
        busRead(A_IN, d, h);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL glitch_in: got %h expected 0", d); end
        busRead(A_STAT, d, h);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL glitch_status: got %h expected 0", d); end
    endtask

    task automatic test_debounce;
        logic [31:0] d;
        logic [31:0] expIn;
        logic [31:0] expStat;
        logic        h;
        @(negedge clk);
        PortIn = 8'hA5;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            expIn   = (k >= 7) ? 32'h0000_00A5 : 32'h0;
            expStat = 32'h0;
            if (k >= 3 && k <= 6) expStat[2] = 1'b1;
            if (k >= 7) expStat[0] = 1'b1;
            busRead(A_IN, d, h);
            checks++;
            if (d !== expIn) begin errors++; $display("[TB] FAIL debounce_in_edge%0d: got %h expected %h", k, d, expIn); end
            busRead(A_STAT, d, h);
            checks++;
            if (d !== expStat) begin errors++; $display("[TB] FAIL debounce_status_edge%0d: got %h expected %h", k, d, expStat); end
        end
    endtask

    task automatic test_w1c;
        logic [31:0] d;
        logic        h;
        busWrite(A_STAT, 32'h1);
        busRead(A_STAT, d, h);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL w1c_clear: got %h expected 0", d); end
        @(negedge clk);
        PortIn = 8'h5A;
        repeat (6) @(posedge clk);
        @(negedge clk);
        Address   = A_STAT;
        WriteData = 32'h1;
        MemWrite  = 1'b1;
        @(negedge clk);
        MemWrite  = 1'b0;
        busRead(A_STAT, d, h);
        checks++;
        if (d !== 32'h1) begin errors++; $display("[TB] FAIL w1c_set_wins: got %h expected 1", d); end
        busRead(A_IN, d, h);
        checks++;
        if (d !== 32'h0000_005A) begin errors++; $display("[TB] FAIL w1c_in: got %h expected %h", d, 32'h5A); end
        busWrite(A_STAT, 32'h1);
    endtask

    task automatic test_outregs;
        logic [31:0] d;
        logic        h;
        busWrite(A_OUT, 32'h1234_5678);
        busWrite(A_XOR, 32'h0000_00FF);
        checks++;
        if (PortOut !== 32'h1234_5687) begin errors++; $display("[TB] FAIL out_portout: got %h expected %h", PortOut, 32'h1234_5687); end
        busRead(A_OUT, d, h);
        checks++;
        if (d !== 32'h1234_5687) begin errors++; $display("[TB] FAIL out_read: got %h expected %h", d, 32'h1234_5687); end
        busRead(A_XOR, d, h);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL xor_read: got %h expected 0", d); end
        busWrite(A_IN, 32'hFFFF_FFFF);
        busRead(A_IN, d, h);
        checks++;
        if (d !== 32'h0000_005A) begin errors++; $display("[TB] FAIL in_readonly: got %h expected %h", d, 32'h5A); end
        Address = A_OUT;
        MemRead = 1'b0;
        #1;
        checks++;
        if (Hit !== 1'b1 || ReadData !== 32'h0) begin errors++; $display("[TB] FAIL hit_noread: got hit=%b data=%h expected hit=1 data=0", Hit, ReadData); end
    endtask

    task automatic test_irq;
        logic [31:0] d;
        logic        h;
`ifdef MMIO_PORT_IRQ_EN
        busWrite(A_STAT, 32'h2);
        busRead(A_STAT, d, h);
        checks++;
        if (d !== 32'h2) begin errors++; $display("[TB] FAIL irq_ie_set: got %h expected 2", d); end
        checks++;
        if (IrqOut !== 1'b0) begin errors++; $display("[TB] FAIL irq_idle: got %b expected 0", IrqOut); end
        PortIn = 8'h11;
        repeat (10) @(negedge clk);
        checks++;
        if (IrqOut !== 1'b1) begin errors++; $display("[TB] FAIL irq_assert: got %b expected 1", IrqOut); end
        busRead(A_STAT, d, h);
        checks++;
        if (d !== 32'h3) begin errors++; $display("[TB] FAIL irq_status: got %h expected 3", d); end
        busWrite(A_STAT, 32'h3);
        checks++;
        if (IrqOut !== 1'b0) begin errors++; $display("[TB] FAIL irq_deassert: got %b expected 0", IrqOut); end
        busRead(A_STAT, d, h);
        checks++;
        if (d !== 32'h2) begin errors++; $display("[TB] FAIL irq_ie_kept: got %h expected 2", d); end
        busWrite(A_STAT, 32'h0);
`else
        busWrite(A_STAT, 32'h2);
        busRead(A_STAT, d, h);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL ie_ignored: got %h expected 0", d); end
        PortIn = 8'h11;
        repeat (10) @(negedge clk);
        checks++;
        if (IrqOut !== 1'b0) begin errors++; $display("[TB] FAIL irq_tied: got %b expected 0", IrqOut); end
        busRead(A_STAT, d, h);
        checks++;
        if (d !== 32'h1) begin errors++; $display("[TB] FAIL poll_status: got %h expected 1", d); end
        busWrite(A_STAT, 32'h1);
`endif
        busRead(A_IN, d, h);
        checks++;
        if (d !== 32'h0000_0011) begin errors++; $display("[TB] FAIL irq_in: got %h expected %h", d, 32'h11); end
    endtask

    task automatic test_out_of_window;
        logic [31:0] d;
        logic        h;
        busWrite(BASE + 32'h10, 32'hAAAA_AAAA);
        busWrite(32'h1000_0000, 32'h5555_5555);
        busWrite(BASE - 32'h4, 32'h0F0F_0F0F);
        checks++;
        if (PortOut !== 32'h1234_5687) begin errors++; $display("[TB] FAIL oow_portout: got %h expected %h", PortOut, 32'h1234_5687); end
        busRead(BASE + 32'h10, d, h);
        checks++;
        if (h !== 1'b0 || d !== 32'h0) begin errors++; $display("[TB] FAIL oow_above: got hit=%b data=%h expected hit=0 data=0", h, d); end
        busRead(32'h1000_0000, d, h);
        checks++;
        if (h !== 1'b0 || d !== 32'h0) begin errors++; $display("[TB] FAIL oow_ram: got hit=%b data=%h expected hit=0 data=0", h, d); end
        busRead(A_STAT, d, h);
        checks++;
        if (d !== 32'h0) begin errors++; $display("[TB] FAIL oow_status: got %h expected 0", d); end
    endtask

    initial begin
        reset     = 1'b1;
        Address   = '0;
        WriteData = '0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        PortIn    = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_glitch();
        test_debounce();
        test_w1c();
        test_outregs();
        test_irq();
        test_out_of_window();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
